// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states, id width.
package irq_ctrl_pkg;

  localparam int IRQ_ID_W = 5;

  localparam logic [2:0] IRQ_REG_PENDING  = 3'd0;
  localparam logic [2:0] IRQ_REG_ENABLE   = 3'd1;
  localparam logic [2:0] IRQ_REG_EDGE     = 3'd2;
  localparam logic [2:0] IRQ_REG_CLAIM    = 3'd3;
  localparam logic [2:0] IRQ_REG_COMPLETE = 3'd4;
  localparam logic [2:0] IRQ_REG_PRIO     = 3'd5;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE    = 2'd0,
    IRQ_ST_REQ     = 2'd1,
    IRQ_ST_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// Per-source input conditioning: optional 2-flop synchroniser plus rising-edge detect.
module irq_ctrl_sync_edge #(
  parameter int SYNC_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic s,
  output logic rise
);

  logic s_dly;

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic sync_p0, sync_p1;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_p0 <= 1'b0;
          sync_p1 <= 1'b0;
        end else begin
          sync_p0 <= raw;
          sync_p1 <= sync_p0;
        end
      end
      assign s = sync_p1;
    end else begin : g_nosync
      assign s = raw;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_dly <= 1'b0;
    else     s_dly <= s;
  end

  assign rise = s & ~s_dly;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending capture, enable/edge regs, winner select, claim/complete FSM.
// Define IRQ_PRIO_EN to add the 2-bit-per-source PRIO register and a registered priority stage.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int TIMER_SRC = 0,
  parameter int SYNC_EN   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [2:0]         a,
  input  logic [31:0]        d,
  input  logic               we,
  output logic [31:0]        spo,
  output logic               interrupt,
  output logic               int_istimer,
  input  logic               int_reply
);

  // Registers are kept 32 bits wide; bits at or above NUM_SRC are forced to constant zero.
  localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << NUM_SRC) - 32'd1);

  logic [NUM_SRC-1:0]  s_vec, rise_vec;
  logic [31:0]         s_w, rise_w, pending, enable, edge_en, cand, w1c, reply_clr;
  irq_state_t          state;
  logic [IRQ_ID_W-1:0] id, req_id;
  logic                req_go, busy, reply_take;
  logic                wr_pend, wr_en, wr_edge, wr_complete;

  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      irq_ctrl_sync_edge #(.SYNC_EN(SYNC_EN)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .raw  (irq_src[g]),
        .s    (s_vec[g]),
        .rise (rise_vec[g])
      );
    end
  endgenerate

  assign s_w    = 32'(s_vec);
  assign rise_w = 32'(rise_vec);

  assign wr_pend     = we && (a == IRQ_REG_PENDING);
  assign wr_en       = we && (a == IRQ_REG_ENABLE);
  assign wr_edge     = we && (a == IRQ_REG_EDGE);
  assign wr_complete = we && (a == IRQ_REG_COMPLETE);

  assign busy       = (state == IRQ_ST_SERVICE);
  assign reply_take = int_reply && (state == IRQ_ST_REQ) && enable[id];
  assign w1c        = wr_pend ? d : 32'd0;
  assign reply_clr  = reply_take ? (32'd1 << id) : 32'd0;
  assign cand       = pending & enable;

  // Edge bits: a new rise beats a same-cycle W1C or reply clear. Level bits mirror the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      enable  <= '0;
      edge_en <= '0;
    end else begin
      pending <= ((edge_en & (rise_w | (pending & ~w1c & ~reply_clr))) | (~edge_en & s_w))
                 & SRC_MASK;
      if (wr_en)   enable  <= d & SRC_MASK;
      if (wr_edge) edge_en <= d & SRC_MASK;
    end
  end

`ifdef IRQ_PRIO_EN
  localparam logic [31:0] PRIO_MASK = (2 * NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'd1 << (2 * NUM_SRC)) - 32'd1);
  logic [31:0]         prio;
  logic                sel_vld, win_vld_p1;
  logic [1:0]          sel_prio;
  logic [IRQ_ID_W-1:0] sel_id, win_id_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              prio <= '0;
    else if (we && (a == IRQ_REG_PRIO)) prio <= d & PRIO_MASK;
  end

  // Strict '>' keeps the lowest index on equal priority.
  always_comb begin
    sel_vld  = 1'b0;
    sel_prio = 2'd0;
    sel_id   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && (!sel_vld || (prio[2*i +: 2] > sel_prio))) begin
        sel_vld  = 1'b1;
        sel_prio = prio[2*i +: 2];
        sel_id   = IRQ_ID_W'(i);
      end
    end
  end

  // ---- priority stage p1 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_vld_p1 <= 1'b0;
      win_id_p1  <= '0;
    end else begin
      win_vld_p1 <= sel_vld;
      win_id_p1  <= sel_id;
    end
  end

  assign req_go = win_vld_p1 && cand[win_id_p1];
  assign req_id = win_id_p1;
`else
  logic [IRQ_ID_W-1:0] sel_id;

  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) sel_id = IRQ_ID_W'(i);
    end
  end

  assign req_go = |cand;
  assign req_id = sel_id;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IRQ_ST_IDLE;
      id        <= '0;
      interrupt <= 1'b0;
    end else begin
      case (state)
        IRQ_ST_IDLE: begin
          if (req_go) begin
            state     <= IRQ_ST_REQ;
            id        <= req_id;
            interrupt <= 1'b1;
          end
        end
        IRQ_ST_REQ: begin
          if (!enable[id]) begin
            state     <= IRQ_ST_IDLE;
            interrupt <= 1'b0;
          end else if (int_reply) begin
            state     <= IRQ_ST_SERVICE;
            interrupt <= 1'b0;
          end
        end
        IRQ_ST_SERVICE: begin
          if (wr_complete && (d[IRQ_ID_W-1:0] == id)) state <= IRQ_ST_IDLE;
        end
        default: begin
          state     <= IRQ_ST_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

  assign int_istimer = interrupt && (id == IRQ_ID_W'(TIMER_SRC));

  always_comb begin
    spo = 32'd0;
    case (a)
      IRQ_REG_PENDING: spo = pending;
      IRQ_REG_ENABLE:  spo = enable;
      IRQ_REG_EDGE:    spo = edge_en;
      IRQ_REG_CLAIM:   spo = {busy, 26'd0, id};
`ifdef IRQ_PRIO_EN
      IRQ_REG_PRIO:    spo = prio;
`endif
      default:         spo = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (NUM_SRC=8, TIMER_SRC=0, SYNC_EN=1).
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        interrupt;
  logic        int_istimer;
  logic        int_reply;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.NUM_SRC(8), .TIMER_SRC(0), .SYNC_EN(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_src     (irq_src),
    .a           (a),
    .d           (d),
    .we          (we),
    .spo         (spo),
    .interrupt   (interrupt),
    .int_istimer (int_istimer),
    .int_reply   (int_reply)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] ad, input logic [31:0] dat);
    a  = ad;
    d  = dat;
    we = 1'b1;
    tick();
    we = 1'b0;
    a  = 3'd0;
    d  = 32'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] ad, input logic [31:0] exp);
    a = ad;
    #1;
    check(tag, spo, exp);
  endtask

  task automatic reply();
    int_reply = 1'b1;
    tick();
    int_reply = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_src = 8'h00; a = 3'd0; d = 32'd0; we = 1'b0; int_reply = 1'b0;
    tick(2);
    check("rst_irq", 32'(interrupt), 32'd0);
    check("rst_tmr", 32'(int_istimer), 32'd0);
    rd_chk("rst_claim", IRQ_REG_CLAIM, 32'd0);
    rd_chk("rst_en", IRQ_REG_ENABLE, 32'd0);
    rst = 1'b0;
    tick();
    rd_chk("rst_pend", IRQ_REG_PENDING, 32'd0);
    rd_chk("rst_edge", IRQ_REG_EDGE, 32'd0);
    wr(IRQ_REG_ENABLE, 32'hFFFF_FFFF);
    rd_chk("en_mask", IRQ_REG_ENABLE, 32'h0000_00FF);
    wr(IRQ_REG_ENABLE, 32'h04);
    wr(IRQ_REG_EDGE, 32'h04);
    rd_chk("unmapped", 3'd6, 32'd0);
`ifndef IRQ_PRIO_EN
    rd_chk("prio_absent", IRQ_REG_PRIO, 32'd0);
`endif

    // edge source 2: one-cycle pulse
    irq_src = 8'h04;
    tick();
    irq_src = 8'h00;
    tick();
    rd_chk("lat_2clk", IRQ_REG_PENDING, 32'd0);
    tick();
    rd_chk("lat_3clk", IRQ_REG_PENDING, 32'h04);
    check("t1_irq_pre", 32'(interrupt), 32'd0);
    tick();
    check("t1_irq", 32'(interrupt), 32'd1);
    rd_chk("t1_claim", IRQ_REG_CLAIM, 32'h0000_0002);
    reply();
    check("t1_irq_off", 32'(interrupt), 32'd0);
    rd_chk("t1_claim_busy", IRQ_REG_CLAIM, 32'h8000_0002);
    rd_chk("t1_pend_clr", IRQ_REG_PENDING, 32'd0);
    wr(IRQ_REG_COMPLETE, 32'd2);
    tick();
    check("t1_idle_irq", 32'(interrupt), 32'd0);
    rd_chk("t1_claim_done", IRQ_REG_CLAIM, 32'h0000_0002);

    // level sources 1 and 5
    wr(IRQ_REG_EDGE, 32'h00);
    wr(IRQ_REG_ENABLE, 32'hFF);
    irq_src = 8'h22;
    tick(4);
    check("t2_irq", 32'(interrupt), 32'd1);
    rd_chk("t2_claim1", IRQ_REG_CLAIM, 32'h0000_0001);
    reply();
    rd_chk("t2_busy1", IRQ_REG_CLAIM, 32'h8000_0001);
    wr(IRQ_REG_COMPLETE, 32'd1);
    check("t2_cmpl_irq", 32'(interrupt), 32'd0);
    tick();
    check("t2_rereq_irq", 32'(interrupt), 32'd1);
    rd_chk("t2_rereq_id", IRQ_REG_CLAIM, 32'h0000_0001);
    reply();
    irq_src = 8'h20;
    tick(3);
    rd_chk("t2_pend5", IRQ_REG_PENDING, 32'h20);
    wr(IRQ_REG_COMPLETE, 32'd1);
    tick();
    check("t2_irq5", 32'(interrupt), 32'd1);
    rd_chk("t2_claim5", IRQ_REG_CLAIM, 32'h0000_0005);
    irq_src = 8'h00;
    tick(3);
    reply();
    wr(IRQ_REG_COMPLETE, 32'd5);
    tick();
    check("t2_quiet", 32'(interrupt), 32'd0);

    // timer indication
    wr(IRQ_REG_ENABLE, 32'h01);
    irq_src = 8'h01;
    tick(4);
    check("t3_irq0", 32'(interrupt), 32'd1);
    check("t3_tmr0", 32'(int_istimer), 32'd1);
    irq_src = 8'h00;
    reply();
    tick(2);
    wr(IRQ_REG_COMPLETE, 32'd0);
    tick();
    check("t3_quiet", 32'(interrupt), 32'd0);
    wr(IRQ_REG_ENABLE, 32'h08);
    irq_src = 8'h08;
    tick(4);
    check("t3_irq3", 32'(interrupt), 32'd1);
    check("t3_tmr3", 32'(int_istimer), 32'd0);
    rd_chk("t3_claim3", IRQ_REG_CLAIM, 32'h0000_0003);

    // masking the claimed id while requesting drops the request
    wr(IRQ_REG_ENABLE, 32'h00);
    tick();
    check("t3_mask_drop", 32'(interrupt), 32'd0);
    wr(IRQ_REG_ENABLE, 32'h08);
    tick();
    check("t3_unmask", 32'(interrupt), 32'd1);

    // service id 3: wrong complete id and stray reply are ignored
    reply();
    wr(IRQ_REG_COMPLETE, 32'd4);
    check("t4_bad_cmpl_irq", 32'(interrupt), 32'd0);
    rd_chk("t4_bad_cmpl", IRQ_REG_CLAIM, 32'h8000_0003);
    reply();
    rd_chk("t4_stray_reply", IRQ_REG_CLAIM, 32'h8000_0003);
    check("t4_stray_irq", 32'(interrupt), 32'd0);
    irq_src = 8'h00;
    tick(3);
    wr(IRQ_REG_COMPLETE, 32'd3);
    rd_chk("t4_done", IRQ_REG_CLAIM, 32'h0000_0003);
    tick();
    check("t4_quiet", 32'(interrupt), 32'd0);

    // edge on source 6 coinciding with W1C of the same bit
    wr(IRQ_REG_ENABLE, 32'h00);
    wr(IRQ_REG_EDGE, 32'h40);
    irq_src = 8'h40;
    tick(2);
    wr(IRQ_REG_PENDING, 32'h40);
    rd_chk("t5_set_wins", IRQ_REG_PENDING, 32'h40);
    wr(IRQ_REG_PENDING, 32'h40);
    rd_chk("t5_w1c", IRQ_REG_PENDING, 32'h00);

`ifdef IRQ_PRIO_EN
    wr(IRQ_REG_EDGE, 32'h00);
    irq_src = 8'h00;
    tick(3);
    wr(IRQ_REG_PRIO, 32'h304);
    wr(IRQ_REG_ENABLE, 32'h12);
    irq_src = 8'h12;
    tick(3);
    rd_chk("p_pend", IRQ_REG_PENDING, 32'h12);
    check("p_irq_c0", 32'(interrupt), 32'd0);
    tick();
    check("p_irq_c1", 32'(interrupt), 32'd0);
    tick();
    check("p_irq_c2", 32'(interrupt), 32'd1);
    rd_chk("p_claim4", IRQ_REG_CLAIM, 32'h0000_0004);
    irq_src = 8'h00;
    reply();
    tick(2);
    wr(IRQ_REG_COMPLETE, 32'd4);
    wr(IRQ_REG_PRIO, 32'h30C);
    rd_chk("p_reg", IRQ_REG_PRIO, 32'h30C);
    irq_src = 8'h12;
    tick(5);
    rd_chk("p_tie", IRQ_REG_CLAIM, 32'h0000_0001);
    irq_src = 8'h40;
    wr(IRQ_REG_ENABLE, 32'h00);
    tick(4);
`endif

    // reset while a request is outstanding
    wr(IRQ_REG_EDGE, 32'h00);
    wr(IRQ_REG_ENABLE, 32'h40);
    tick();
    check("t6_req", 32'(interrupt), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_irq", 32'(interrupt), 32'd0);
    check("t6_rst_tmr", 32'(int_istimer), 32'd0);
    rd_chk("t6_rst_claim", IRQ_REG_CLAIM, 32'd0);
    rd_chk("t6_rst_pend", IRQ_REG_PENDING, 32'd0);
    rd_chk("t6_rst_en", IRQ_REG_ENABLE, 32'd0);
    tick();
    rst = 1'b0;
    irq_src = 8'h00;
    tick(4);
    check("t6_post_irq", 32'(interrupt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
